// File: rtl/zf_bridge_pkg.sv
// Shared constants and FSM state type for the two-port Avalon bridge arbiter.
package zf_bridge_pkg;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 16;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/zf_bridge_arbiter_if.sv
// Requester and bridge signals of the arbiter; slave is the arbiter's view,
// master is the view of the requesters plus the external bridge.
interface zf_bridge_arbiter_if #(
  parameter int ADDR_W = zf_bridge_pkg::ADDR_W,
  parameter int DATA_W = zf_bridge_pkg::DATA_W,
  parameter int BE_W   = zf_bridge_pkg::BE_W
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [BE_W-1:0]   m0_be;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_done;
  logic              m0_err;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [BE_W-1:0]   m1_be;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_done;
  logic              m1_err;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] br_address;
  logic [BE_W-1:0]   br_byte_enable;
  logic              br_read;
  logic              br_write;
  logic [DATA_W-1:0] br_write_data;
  logic              br_acknowledge;
  logic [DATA_W-1:0] br_read_data;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_be, m0_wdata,
    output m0_done, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_be, m1_wdata,
    output m1_done, m1_err, m1_rdata,
    output br_address, br_byte_enable, br_read, br_write, br_write_data,
    input  br_acknowledge, br_read_data
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_be, m0_wdata,
    input  m0_done, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_be, m1_wdata,
    input  m1_done, m1_err, m1_rdata,
    input  br_address, br_byte_enable, br_read, br_write, br_write_data,
    output br_acknowledge, br_read_data
  );

endinterface

// File: rtl/zf_rr_arb2.sv
// Two-way round-robin winner selection; last_grant starts at 1 so port 0 wins first.
module zf_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       gnt_any,
  output logic       gnt_idx
);

  logic last_grant;

  always_comb begin
    gnt_any = |req;
    if (req == 2'b11) gnt_idx = ~last_grant;
    else              gnt_idx = req[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_grant <= 1'b1;
    else if (grant_en) last_grant <= gnt_idx;
  end

endmodule

// File: rtl/zf_bridge_arbiter.sv
// Shares one Avalon bridge between two requesters: round-robin grant, one
// single-word transaction at a time, completed by acknowledge or timeout.
module zf_bridge_arbiter #(
  parameter int ADDR_W  = zf_bridge_pkg::ADDR_W,
  parameter int DATA_W  = zf_bridge_pkg::DATA_W,
  parameter int BE_W    = zf_bridge_pkg::BE_W,
  parameter int TIMEOUT = 255
) (
  input logic                clk_clk,
  input logic                reset_reset_n,
  zf_bridge_arbiter_if.slave bus
);
  import zf_bridge_pkg::*;

  // Counter value on the last strobe cycle before the transaction is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic              owner;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic [1:0]        done_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic [1:0]        req;
  logic              gnt_any;
  logic              gnt_idx;
  logic              grant_en;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;

  assign req      = {bus.m1_req, bus.m0_req};
  assign grant_en = (state == IDLE) && gnt_any;

  zf_rr_arb2 u_rr (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .req      (req),
    .grant_en (grant_en),
    .gnt_any  (gnt_any),
    .gnt_idx  (gnt_idx)
  );

  always_comb begin
    sel_we    = gnt_idx ? bus.m1_we    : bus.m0_we;
    sel_addr  = gnt_idx ? bus.m1_addr  : bus.m0_addr;
    sel_be    = gnt_idx ? bus.m1_be    : bus.m0_be;
    sel_wdata = gnt_idx ? bus.m1_wdata : bus.m0_wdata;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      cnt      <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            owner   <= gnt_idx;
            addr_q  <= sel_addr;
            be_q    <= sel_be;
            wdata_q <= sel_wdata;
            rd_q    <= ~sel_we;
            wr_q    <= sel_we;
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // Acknowledge takes priority over a timeout expiring in the same cycle.
          if (bus.br_acknowledge) begin
            if (rd_q) begin
              if (owner) rdata1_q <= bus.br_read_data;
              else       rdata0_q <= bus.br_read_data;
            end
            done_q[owner] <= 1'b1;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            state         <= IDLE;
          end else if (cnt == TO_LAST) begin
            done_q[owner] <= 1'b1;
            err_q[owner]  <= 1'b1;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.br_address     = addr_q;
  assign bus.br_byte_enable = be_q;
  assign bus.br_read        = rd_q;
  assign bus.br_write       = wr_q;
  assign bus.br_write_data  = wdata_q;
  assign bus.m0_done        = done_q[0];
  assign bus.m1_done        = done_q[1];
  assign bus.m0_err         = err_q[0];
  assign bus.m1_err         = err_q[1];
  assign bus.m0_rdata       = rdata0_q;
  assign bus.m1_rdata       = rdata1_q;

endmodule

// File: doc/zf_bridge_arbiter.md
# zf_bridge_arbiter

Two-port arbiter sharing the SoC's 16-bit external Avalon bridge (26-bit word address, byte enables, read/write, acknowledge) between two fabric-side requesters, e.g. the video framebuffer reader (port 0) and the audio sample DMA (port 1). It grants the bridge round-robin, runs one single-word transaction at a time to completion on `acknowledge`, and returns read data or a timeout error to the granted requester. It sits between the multimedia engines and the `avalon_bridge_*` ports of the ZFsoc system.

## Interface
Parameters:
- `ADDR_W`, 26: bridge address width.
- `DATA_W`, 16: bridge data width.
- `BE_W`, 2: byte-enable width, `DATA_W/8`.
- `TIMEOUT`, 255: cycles to wait for `acknowledge` before aborting; range 1..255 (8-bit counter).

Ports:
- `clk_clk`  in  1  single system clock; everything is synchronous to its rising edge.
- `reset_reset_n`  in  1  reset, asynchronous and active-low.
- `mN_req`  in  1  (N=0,1) transaction request; level, held until `mN_done`.
- `mN_we`  in  1  1 = write, 0 = read.
- `mN_addr`  in  ADDR_W  word address.
- `mN_be`  in  BE_W  byte enables.
- `mN_wdata`  in  DATA_W  write data.
- `mN_done`  out  1  one-cycle completion pulse.
- `mN_err`  out  1  valid with `mN_done`; 1 = timed out.
- `mN_rdata`  out  DATA_W  read data; valid while `mN_done`=1, held afterward.
- `br_address`  out  ADDR_W  to `avalon_bridge_address`.
- `br_byte_enable`  out  BE_W  to `avalon_bridge_byte_enable`.
- `br_read`  out  1  to `avalon_bridge_read`.
- `br_write`  out  1  to `avalon_bridge_write`.
- `br_write_data`  out  DATA_W  to `avalon_bridge_write_data`.
- `br_acknowledge`  in  1  from `avalon_bridge_acknowledge`.
- `br_read_data`  in  DATA_W  from `avalon_bridge_read_data`.

## Operation
- FSM states: IDLE, BUSY.
- IDLE:
  - If any `mN_req`=1, pick a winner, register its `we`/`addr`/`be`/`wdata` onto the `br_*` outputs, set `br_read` or `br_write`, clear the timeout counter, record `owner`, and go to BUSY.
  - Round-robin: with both requesting, the port not equal to `last_grant` wins. `last_grant` updates at grant.
- BUSY:
  - Strobe and all `br_*` fields are held stable.
  - `br_acknowledge`=1: capture `br_read_data` into `m<owner>_rdata` (reads only), pulse `m<owner>_done` with `err`=0, drop the strobe, go to IDLE.
  - Counter reaches `TIMEOUT` with no ack: drop the strobe, pulse `done` with `err`=1, leave `rdata` unchanged, go to IDLE.
  - Ack in the same cycle as expiry: ack wins, `err`=0.
- `br_acknowledge` in IDLE is ignored.
- A requester deasserting `req` mid-transaction does not abort it; `done` still pulses.
- Reset values: `br_read`=`br_write`=0, `br_address`/`br_byte_enable`/`br_write_data`=0, `mN_done`=`mN_err`=0, `mN_rdata`=0, `last_grant`=1 (port 0 wins first), state IDLE.
- Reset asserted mid-transaction: the strobe drops immediately (asynchronously) and no `done` is issued.

## Timing
- Request seen in IDLE at cycle T: strobe and fields driven at T+1.
- Ack sampled at cycle A: `done` and strobe deassertion at A+1, state IDLE at A+1.
- A `req` still high at A+1 is evaluated at A+1, so the next strobe starts at A+2. There is at least one strobe-low cycle between transactions.
- Minimum turnaround: 3 cycles per transaction with ack on the first strobe cycle.
- Timeout: strobe high for exactly `TIMEOUT` cycles, `done`/`err` on the following cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `zf_bridge_pkg`: `ADDR_W`, `DATA_W`, `BE_W` constants; state enum `{IDLE, BUSY}`.
- Sub-module `zf_rr_arb2`: combinational winner selection from `req[1:0]` and `last_grant`, plus the registered `last_grant` update. The FSM, counter and datapath muxing stay in `zf_bridge_arbiter`.

## Test plan
- Reset then single read, port 0 at `addr`=0x0000123, bridge acks 2 cycles after strobe with 0xBEEF -> `br_read` high 2 cycles; `m0_done`=1, `m0_err`=0, `m0_rdata`=0xBEEF one cycle after ack.
- Both ports request writes every cycle, ack after 1 cycle -> grants alternate 0,1,0,1; each strobe is separated by ≥1 idle cycle; `br_write_data` matches the granted port's `wdata` and `be`.
- `TIMEOUT`=4, no ack -> strobe high exactly 4 cycles, then `m1_done`=1, `m1_err`=1, `m1_rdata` unchanged.
- Ack on the same cycle as timeout expiry -> `err`=0, read data captured.
- Assert `reset_reset_n`=0 during BUSY -> strobe low immediately, no `done`. After release, port 0 wins when both ports request.
- Spurious ack in IDLE plus `m0_req` dropped mid-transaction -> spurious ack is ignored; the in-flight transaction completes with `m0_done` pulse.
